// File: rtl/reg_arb_rr.sv
// Round-robin arbiter with per-requester lock into a single registered output slot.
// A locked owner keeps the grant for up to LOCK_MAX beats, then the grant rotates past it.
module reg_arb_rr #(
  parameter int DATA_WIDTH = 32,
  parameter int REQ_NUM    = 4,
  parameter int LOCK_MAX   = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [REQ_NUM-1:0]            i_req_valid,
  input  logic [REQ_NUM-1:0]            i_req_lock,
  input  logic [REQ_NUM*DATA_WIDTH-1:0] i_req_data,
  output logic [REQ_NUM-1:0]            o_req_ready,
  output logic                          o_valid,
  output logic [DATA_WIDTH-1:0]         o_data,
  output logic [$clog2(REQ_NUM)-1:0]    o_src,
  input  logic                          i_ready,
  output logic                          o_lock
);

  localparam int IW = $clog2(REQ_NUM);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [IW-1:0]         owner_q, owner_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  o_valid_q, o_valid_d;
  logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
  logic [IW-1:0]         o_src_q, o_src_d;

  logic          slot_free;
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic          xfer;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] k);
    return (int'(k) == REQ_NUM - 1) ? '0 : k + 1'b1;
  endfunction

  assign slot_free = !o_valid_q || i_ready;

  // Winner selection: the locked owner only, otherwise first valid from ptr upward.
  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default first so no path infers a latch.
    idx       = 0;
    win_found = 1'b0;
    win_idx   = ptr_q;
    if (state_q == ST_LOCK) begin
      win_found = i_req_valid[owner_q];
      win_idx   = owner_q;
    end else begin
      // Scan farthest-first so the nearest valid requester is the last one written.
      for (int i = REQ_NUM - 1; i >= 0; i--) begin
        idx = int'(ptr_q) + i;
        if (idx >= REQ_NUM) idx = idx - REQ_NUM;
        if (i_req_valid[idx]) begin
          win_found = 1'b1;
          win_idx   = IW'(idx);
        end
      end
    end
  end

  always_comb begin
    o_req_ready = '0;
    if (!i_rst && slot_free && win_found) o_req_ready[win_idx] = 1'b1;
  end

  assign xfer = |o_req_ready;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_src_d   = o_src_q;

    if (xfer) begin
      o_valid_d = 1'b1;
      o_data_d  = i_req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
      o_src_d   = win_idx;
    end else if (i_ready) begin
      o_valid_d = 1'b0;
    end

    if (xfer) begin
      if (state_q == ST_IDLE) begin
        // With LOCK_MAX of 1 the first beat already exhausts the lock.
        if (i_req_lock[win_idx] && LOCK_MAX > 1) begin
          state_d = ST_LOCK;
          owner_d = win_idx;
          cnt_d   = 8'd1;
        end else begin
          ptr_d = next_idx(win_idx);
        end
      end else begin
        if (!i_req_lock[owner_q] || int'(cnt_q) + 1 >= LOCK_MAX) begin
          state_d = ST_IDLE;
          ptr_d   = next_idx(owner_q);
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  // NOTE: the output data register is reset too, because its reset value is observable.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      cnt_q     <= 8'd0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_src_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_src_q   <= o_src_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign o_src   = o_src_q;
  assign o_lock  = (state_q == ST_LOCK);

endmodule

// File: tb/tb_reg_arb_rr.sv
// Directed bench for reg_arb_rr: rotation, single requester, backpressure, lock,
// forced release and reset in the middle of a lock.
module tb_reg_arb_rr;

  localparam int DW = 32;
  localparam int RN = 4;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [RN-1:0] i_req_valid;
  logic [RN-1:0] i_req_lock;
  logic [RN*DW-1:0] i_req_data;
  logic [RN-1:0] o_req_ready;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic [1:0]    o_src;
  logic          i_ready;
  logic          o_lock;

  int errors = 0;
  int checks = 0;

  reg_arb_rr #(.DATA_WIDTH(DW), .REQ_NUM(RN), .LOCK_MAX(4)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .i_req_lock  (i_req_lock),
    .i_req_data  (i_req_data),
    .o_req_ready (o_req_ready),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .o_src       (o_src),
    .i_ready     (i_ready),
    .o_lock      (o_lock)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; checks run 1 time unit later.
  task automatic step();
    @(negedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst       = 1'b1;
    i_req_valid = '0;
    i_req_lock  = '0;
    step();
    i_rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst       = 1'b1;
    i_ready     = 1'b1;
    i_req_valid = 4'b1111;
    i_req_lock  = '0;
    for (int k = 0; k < RN; k++) i_req_data[k*DW +: DW] = k;

    // Reset: no grant while held, outputs cleared.
    #1;
    check("rst_ready", 32'(o_req_ready), 32'h0);
    step();
    check("rst_ready_held", 32'(o_req_ready), 32'h0);
    check("rst_valid", 32'(o_valid), 32'h0);
    check("rst_data", o_data, 32'h0);
    check("rst_src", 32'(o_src), 32'h0);
    check("rst_lock", 32'(o_lock), 32'h0);

    // All valid, no lock: grants 0,1,2,3,0,1 back to back with no bubble.
    i_rst = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rr_ready_%0d", i), 32'(o_req_ready), 32'(1 << (i % 4)));
      if (i > 0) begin
        check($sformatf("rr_valid_%0d", i), 32'(o_valid), 32'h1);
        check($sformatf("rr_src_%0d", i), 32'(o_src), 32'((i - 1) % 4));
        check($sformatf("rr_data_%0d", i), o_data, 32'((i - 1) % 4));
      end
      step();
    end
    check("rr_src_last", 32'(o_src), 32'h1);
    i_req_valid = '0;
    #1;
    check("idle_ready", 32'(o_req_ready), 32'h0);
    step();
    check("idle_valid_clear", 32'(o_valid), 32'h0);

    // Only requester 2 valid.
    i_req_valid = 4'b0100;
    i_req_data[2*DW +: DW] = 32'hDEAD_BEEF;
    #1;
    check("one_ready", 32'(o_req_ready), 32'h4);
    step();
    check("one_valid", 32'(o_valid), 32'h1);
    check("one_data", o_data, 32'hDEAD_BEEF);
    check("one_src", 32'(o_src), 32'h2);

    // Backpressure: output held, nothing granted, then immediate grant on release.
    i_req_valid = 4'b0010;
    i_req_data[1*DW +: DW] = 32'h1111_1111;
    i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp_ready_%0d", i), 32'(o_req_ready), 32'h0);
      check($sformatf("bp_data_%0d", i), o_data, 32'hDEAD_BEEF);
      check($sformatf("bp_valid_%0d", i), 32'(o_valid), 32'h1);
      step();
    end
    i_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(o_req_ready), 32'h2);
    step();
    check("bp_new_data", o_data, 32'h1111_1111);
    check("bp_new_src", 32'(o_src), 32'h1);
    i_req_valid = '0;

    // Lock by requester 0 for two beats then unlocked third beat; requester 3 waits.
    do_reset();
    i_req_valid = 4'b1001;
    i_req_lock  = 4'b0001;
    #1;
    check("lk_ready_0", 32'(o_req_ready), 32'h1);
    check("lk_lock_0", 32'(o_lock), 32'h0);
    step();
    check("lk_src_1", 32'(o_src), 32'h0);
    check("lk_lock_1", 32'(o_lock), 32'h1);
    check("lk_ready_1", 32'(o_req_ready), 32'h1);
    step();
    check("lk_src_2", 32'(o_src), 32'h0);
    check("lk_lock_2", 32'(o_lock), 32'h1);
    i_req_lock = 4'b0000;
    #1;
    check("lk_ready_2", 32'(o_req_ready), 32'h1);
    step();
    check("lk_src_3", 32'(o_src), 32'h0);
    check("lk_lock_3", 32'(o_lock), 32'h0);
    check("lk_ready_3", 32'(o_req_ready), 32'h8);
    step();
    check("lk_src_4", 32'(o_src), 32'h3);
    check("lk_lock_4", 32'(o_lock), 32'h0);
    i_req_valid = '0;

    // Permanent lock by requester 1: four beats, a valid gap mid-lock, then forced release.
    i_req_valid = 4'b0110;
    i_req_lock  = 4'b0010;
    i_req_data[1*DW +: DW] = 32'hA1;
    i_req_data[2*DW +: DW] = 32'hB2;
    #1;
    for (int b = 0; b < 4; b++) begin
      check($sformatf("fr_ready_%0d", b), 32'(o_req_ready), 32'h2);
      step();
      check($sformatf("fr_src_%0d", b), 32'(o_src), 32'h1);
      check($sformatf("fr_lock_%0d", b), 32'(o_lock), (b < 3) ? 32'h1 : 32'h0);
      if (b == 1) begin
        i_req_valid = 4'b0100;
        #1;
        check("fr_gap_ready", 32'(o_req_ready), 32'h0);
        step();
        check("fr_gap_lock", 32'(o_lock), 32'h1);
        check("fr_gap_valid", 32'(o_valid), 32'h0);
        i_req_valid = 4'b0110;
        #1;
      end
    end
    check("fr_next_ready", 32'(o_req_ready), 32'h4);
    step();
    check("fr_next_src", 32'(o_src), 32'h2);
    check("fr_next_data", o_data, 32'hB2);
    i_req_valid = '0;
    i_req_lock  = '0;

    // Reset while locked with a word held.
    i_req_valid = 4'b0001;
    i_req_lock  = 4'b0001;
    i_req_data[0*DW +: DW] = 32'hC0;
    step();
    check("mr_lock", 32'(o_lock), 32'h1);
    check("mr_valid", 32'(o_valid), 32'h1);
    i_rst = 1'b1;
    #1;
    check("mr_ready_in_rst", 32'(o_req_ready), 32'h0);
    step();
    check("mr_valid_clr", 32'(o_valid), 32'h0);
    check("mr_lock_clr", 32'(o_lock), 32'h0);
    check("mr_data_clr", o_data, 32'h0);
    i_rst       = 1'b0;
    i_req_valid = 4'b1111;
    i_req_lock  = '0;
    #1;
    check("mr_ready_after", 32'(o_req_ready), 32'h1);
    step();
    check("mr_src_after", 32'(o_src), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
